// File: rtl/present_sp_layer.sv
// -----------------------------------------------------------------------------
// present_sp_layer
//
// Registered PRESENT-80 substitution/permutation round layer. It provides the
// 4-bit PRESENT S-box on 16 data lanes, plus one key-schedule lane, and the
// 64-bit PRESENT bit permutation (P-layer). Both sit behind one clocked
// interface. The mode input selects bypass, S-box only, P-layer only, or
// S-box followed by P-layer.
//
// Ports:
//   clk        rising-edge clock
//   iReset_n   synchronous active-low reset
//   in_valid   capture request for idat/knib this cycle
//   mode       00 bypass, 01 S-box, 10 P-layer, 11 S-box then P-layer
//   idat       64-bit data state
//   knib       key-schedule nibble (key bits 79:76 after rotation)
//   odat       registered layer result
//   kodat      registered S-box(knib), independent of mode
//   out_valid  result valid strobe, one cycle after the in_valid sample
// -----------------------------------------------------------------------------
module present_sp_layer (
   input  logic        clk,
   input  logic        iReset_n,
   input  logic        in_valid,
   input  logic [1:0]  mode,
   input  logic [63:0] idat,
   input  logic [3:0]  knib,
   output logic [63:0] odat,
   output logic [3:0]  kodat,
   output logic        out_valid
);

   // PRESENT 4-bit S-box. The table is bijective and covers all 16 inputs.
   // The default arm is unreachable and exists only to keep the decode total.
   function automatic logic [3:0] present_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0:    y = 4'hC;
         4'h1:    y = 4'h5;
         4'h2:    y = 4'h6;
         4'h3:    y = 4'hB;
         4'h4:    y = 4'h9;
         4'h5:    y = 4'h0;
         4'h6:    y = 4'hA;
         4'h7:    y = 4'hD;
         4'h8:    y = 4'h3;
         4'h9:    y = 4'hE;
         4'hA:    y = 4'hF;
         4'hB:    y = 4'h8;
         4'hC:    y = 4'h4;
         4'hD:    y = 4'h7;
         4'hE:    y = 4'h1;
         4'hF:    y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   logic [63:0] s_layer_s;   // S-box applied to every nibble of idat
   logic [63:0] p_src_s;     // P-layer input: idat or s_layer_s
   logic [63:0] p_layer_s;   // permuted p_src_s
   logic [63:0] result_s;    // mode-selected combinational result
   logic [3:0]  ksbox_s;     // key-lane S-box output

   logic [63:0] odat_r;
   logic [3:0]  kodat_r;
   logic        out_valid_r;

   // Sixteen identical S-box lanes, one per nibble.
   genvar n;
   generate
      for (n = 0; n < 16; n++) begin : g_sbox
         assign s_layer_s[4*n+3:4*n] = present_sbox(idat[4*n+3:4*n]);
      end
   endgenerate

   assign ksbox_s = present_sbox(knib);

   // Choose the P-layer source: S-layer output when mode[0] requests substitution.
   always_comb begin
      p_src_s = idat;
      if (mode[0]) begin
         p_src_s = s_layer_s;
      end else begin
         p_src_s = idat;
      end
   end

   // P-layer is pure wiring. Bit 4j+k of the source lands on output bit j+16k.
   // Bit 63 (j=15, k=3) maps onto itself.
   genvar j, k;
   generate
      for (j = 0; j < 16; j++) begin : g_perm_j
         for (k = 0; k < 4; k++) begin : g_perm_k
            assign p_layer_s[j+16*k] = p_src_s[4*j+k];
         end
      end
   endgenerate

   // Mode decode of the combinational layer result.
   always_comb begin
      result_s = idat;
      case (mode)
         2'b00:   result_s = idat;
         2'b01:   result_s = s_layer_s;
         2'b10:   result_s = p_layer_s;
         2'b11:   result_s = p_layer_s;
         default: result_s = idat;
      endcase
   end

   // Output registers. Reset wins over capture. Data holds while idle, and the
   // strobe is high only in the cycle after a capture.
   always_ff @(posedge clk) begin
      if (!iReset_n) begin
         odat_r      <= 64'h0;
         kodat_r     <= 4'h0;
         out_valid_r <= 1'b0;
      end else if (in_valid) begin
         odat_r      <= result_s;
         kodat_r     <= ksbox_s;
         out_valid_r <= 1'b1;
      end else begin
         odat_r      <= odat_r;
         kodat_r     <= kodat_r;
         out_valid_r <= 1'b0;
      end
   end

   assign odat      = odat_r;
   assign kodat     = kodat_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_present_sp_layer.sv
// -----------------------------------------------------------------------------
// tb_present_sp_layer
//
// Directed self-checking bench for present_sp_layer. Stimulus changes on the
// falling clock edge. Outputs are sampled 1 ns after the rising edge that
// captured the stimulus.
// -----------------------------------------------------------------------------
module tb_present_sp_layer;

   logic        clk;
   logic        iReset_n;
   logic        in_valid;
   logic [1:0]  mode;
   logic [63:0] idat;
   logic [3:0]  knib;
   logic [63:0] odat;
   logic [3:0]  kodat;
   logic        out_valid;

   int vectors;
   int miscompares;

   // PRESENT S-box table, written out for x = 0..F.
   logic [3:0] sbox_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   present_sp_layer dut (
      .clk       (clk),
      .iReset_n  (iReset_n),
      .in_valid  (in_valid),
      .mode      (mode),
      .idat      (idat),
      .knib      (knib),
      .odat      (odat),
      .kodat     (kodat),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inverse P-layer. Output bit o = j + 16k came from input bit 4j + k.
   function automatic logic [63:0] inv_perm(input logic [63:0] x);
      logic [63:0] r;
      r = 64'h0;
      for (int o = 0; o < 64; o++) begin
         r[4*(o%16) + o/16] = x[o];
      end
      return r;
   endfunction

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Present one capture request and step just past the capturing edge.
   task automatic apply(input logic [1:0] m, input logic [63:0] d, input logic [3:0] k);
      @(negedge clk);
      in_valid = 1'b1;
      mode     = m;
      idat     = d;
      knib     = k;
      @(posedge clk);
      #1;
   endtask

   // Idle cycle with in_valid low and junk on the data inputs.
   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      mode     = 2'b11;
      idat     = 64'hDEAD_BEEF_0BAD_F00D;
      knib     = 4'h9;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] rnd;
      vectors     = 0;
      miscompares = 0;

      // Reset held across two edges with an active capture request.
      iReset_n = 1'b0;
      in_valid = 1'b1;
      mode     = 2'b11;
      idat     = 64'hFFFF_FFFF_FFFF_FFFF;
      knib     = 4'hF;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk64("reset_odat",  odat,      64'h0);
      chk4 ("reset_kodat", kodat,     4'h0);
      chk1 ("reset_valid", out_valid, 1'b0);

      @(negedge clk);
      iReset_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk1("idle_after_reset_valid", out_valid, 1'b0);

      // S-box only.
      apply(2'b01, 64'h0123_4567_89AB_CDEF, 4'h0);
      chk64("sbox_odat",  odat,      64'hC56B_90AD_3EF8_4712);
      chk4 ("sbox_kodat", kodat,     4'hC);
      chk1 ("sbox_valid", out_valid, 1'b1);

      // P-layer on single bits.
      apply(2'b10, 64'h0000_0000_0000_0001, 4'h1);
      chk64("perm_bit0", odat, 64'h0000_0000_0000_0001);
      chk4 ("perm_bit0_kodat", kodat, 4'h5);
      apply(2'b10, 64'h0000_0000_0000_0002, 4'h2);
      chk64("perm_bit1", odat, 64'h0000_0000_0001_0000);
      apply(2'b10, 64'h4000_0000_0000_0000, 4'h3);
      chk64("perm_bit62", odat, 64'h0000_8000_0000_0000);
      apply(2'b10, 64'h8000_0000_0000_0000, 4'h4);
      chk64("perm_bit63", odat, 64'h8000_0000_0000_0000);

      // S then P. S(0)=C sets nibble bits 2,3, which land on bits 32..63.
      apply(2'b11, 64'h0, 4'h5);
      chk64("sp_zero", odat, 64'hFFFF_FFFF_0000_0000);
      // S(F)=2 sets nibble bit 1 only, which lands on bits 16..31.
      apply(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 4'h6);
      chk64("sp_ones", odat, 64'h0000_0000_FFFF_0000);

      // Three back-to-back captures with modes 00, 01, 10.
      apply(2'b00, 64'hA5A5_1234_5678_9ABC, 4'h7);
      chk64("stream0_odat",  odat,      64'hA5A5_1234_5678_9ABC);
      chk1 ("stream0_valid", out_valid, 1'b1);
      apply(2'b01, 64'h0123_4567_89AB_CDEF, 4'h8);
      chk64("stream1_odat",  odat,      64'hC56B_90AD_3EF8_4712);
      chk1 ("stream1_valid", out_valid, 1'b1);
      apply(2'b10, 64'h0000_0000_0000_0002, 4'h9);
      chk64("stream2_odat",  odat,      64'h0000_0000_0001_0000);
      chk1 ("stream2_valid", out_valid, 1'b1);
      chk4 ("stream2_kodat", kodat,     4'hE);

      // Drop in_valid: the data holds and the strobe falls.
      idle();
      chk1 ("hold1_valid", out_valid, 1'b0);
      chk64("hold1_odat",  odat,      64'h0000_0000_0001_0000);
      chk4 ("hold1_kodat", kodat,     4'hE);
      idle();
      chk1 ("hold2_valid", out_valid, 1'b0);
      chk64("hold2_odat",  odat,      64'h0000_0000_0001_0000);

      // Reset mid-stream discards the pending capture. The first capture
      // after release produces a fresh result.
      @(negedge clk);
      in_valid = 1'b1;
      mode     = 2'b00;
      idat     = 64'h1111_2222_3333_4444;
      iReset_n = 1'b0;
      @(posedge clk);
      #1;
      chk64("midreset_odat",  odat,      64'h0);
      chk1 ("midreset_valid", out_valid, 1'b0);
      @(negedge clk);
      iReset_n = 1'b1;
      apply(2'b00, 64'h1111_2222_3333_4444, 4'hA);
      chk64("post_reset_odat",  odat,      64'h1111_2222_3333_4444);
      chk1 ("post_reset_valid", out_valid, 1'b1);

      // Key lane sweep across all 16 nibbles.
      for (int i = 0; i < 16; i++) begin
         apply(2'b00, 64'h0, i[3:0]);
         chk4("key_lane", kodat, sbox_tbl[i]);
      end

      // P-layer round trip through the inverse permutation.
      for (int i = 0; i < 1000; i++) begin
         rnd = {$urandom(), $urandom()};
         apply(2'b10, rnd, 4'h0);
         chk64("inv_perm", inv_perm(odat), rnd);
      end

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
